// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control for EX, stalls on load-use
// hazards, bubbles on hazard or flush, forwards same-cycle WB writes, and counts stalls/flushes.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_IR,
  input  logic [31:0]      id_RegA,
  input  logic [31:0]      id_RegB,
  input  logic [31:0]      id_PC_plus_4,
  input  logic [31:0]      id_LU_out,
  input  logic             id_ALUSrc1,
  input  logic             id_ALUSrc2,
  input  logic [3:0]       id_ALUOp,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic [1:0]       id_RegDst,
  input  logic             flush,
  input  logic             wb_RegWrite,
  input  logic [4:0]       wb_WriteAddr,
  input  logic [31:0]      wb_WriteData,
  output logic [31:0]      IR,
  output logic [31:0]      RegA,
  output logic [31:0]      RegB,
  output logic [31:0]      PC_plus_4,
  output logic [31:0]      LU_out,
  output logic             ALUSrc1,
  output logic             ALUSrc2,
  output logic [3:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic [4:0]       WriteAddr,
  output logic             valid,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        hazard;
  logic        bypass_a;
  logic        bypass_b;
  logic [4:0]  dest_addr;

  assign id_rs = id_IR[25:21];
  assign id_rt = id_IR[20:16];
  assign id_rd = id_IR[15:11];

  // Hazard looks only at registered EX state and the ID instruction, never at wb_* inputs.
  assign hazard = valid && MemRead && (WriteAddr != 5'd0) &&
                  ((WriteAddr == id_rs) || (WriteAddr == id_rt));
  assign stall  = hazard && !flush;

  assign bypass_a = wb_RegWrite && (wb_WriteAddr != 5'd0) && (wb_WriteAddr == id_rs);
  assign bypass_b = wb_RegWrite && (wb_WriteAddr != 5'd0) && (wb_WriteAddr == id_rt);

  always_comb begin
    dest_addr = id_rt;
    case (id_RegDst)
      2'b01:   dest_addr = id_rd;
      2'b10:   dest_addr = 5'd31;
      default: dest_addr = id_rt;
    endcase
  end

  // Pipeline register; flush and hazard both load a bubble with valid cleared.
  always_ff @(posedge clk) begin
    if (reset || flush || hazard) begin
      IR        <= 32'd0;
      RegA      <= 32'd0;
      RegB      <= 32'd0;
      PC_plus_4 <= 32'd0;
      LU_out    <= 32'd0;
      ALUSrc1   <= 1'b0;
      ALUSrc2   <= 1'b0;
      ALUOp     <= 4'd0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      RegWrite  <= 1'b0;
      MemtoReg  <= 1'b0;
      WriteAddr <= 5'd0;
      valid     <= 1'b0;
    end else begin
      IR        <= id_IR;
      RegA      <= bypass_a ? wb_WriteData : id_RegA;
      RegB      <= bypass_b ? wb_WriteData : id_RegB;
      PC_plus_4 <= id_PC_plus_4;
      LU_out    <= id_LU_out;
      ALUSrc1   <= id_ALUSrc1;
      ALUSrc2   <= id_ALUSrc2;
      ALUOp     <= id_ALUOp;
      MemRead   <= id_MemRead;
      MemWrite  <= id_MemWrite;
      RegWrite  <= id_RegWrite;
      MemtoReg  <= id_MemtoReg;
      WriteAddr <= dest_addr;
      valid     <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_ONE;
      if (flush && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule
